// File: rtl/vu_meter_pwm_array_if.sv
// Bus bundle for vu_meter_pwm_array.
// master: audio/control source (sample strobes, samples, mode, test level),
//         reads back the ballistic level and the PWM drive.
// slave : the VU meter driver itself.
//   data_en      per-channel single-cycle sample strobe
//   audio_enable high while audio plays; low clears measurement state
//   audio_signal channel i at [i*SAMPLE_W +: SAMPLE_W], two's complement
//   mode         0 average, 1 peak-hold, 2 test, 3 as 0
//   test_level   duty used by every channel in test mode
//   level        ballistic level per channel (readback)
//   vu_out       PWM drive per channel
interface vu_meter_pwm_array_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned PWM_RES  = 7
);
  logic [NUM_CH-1:0]          data_en;
  logic                       audio_enable;
  logic [NUM_CH*SAMPLE_W-1:0] audio_signal;
  logic [1:0]                 mode;
  logic [PWM_RES-1:0]         test_level;
  logic [NUM_CH*PWM_RES-1:0]  level;
  logic [NUM_CH-1:0]          vu_out;

  modport master (
    output data_en, audio_enable, audio_signal, mode, test_level,
    input  level, vu_out
  );

  modport slave (
    input  data_en, audio_enable, audio_signal, mode, test_level,
    output level, vu_out
  );
endinterface

// File: rtl/vu_meter_pwm_array.sv
// Multi-channel VU meter driver: rectify strobed samples, average over a
// power-of-two window, apply average or peak-hold/linear-release ballistics,
// and render each level as a frame-aligned PWM.
// Ports:
//   clk   system clock
//   reset asynchronous active-high, clears all state
//   bus   vu_meter_pwm_array_if slave (samples/control in, level/vu_out out)
module vu_meter_pwm_array #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned PWM_RES  = 7,
  parameter int unsigned PWM_DIV  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  vu_meter_pwm_array_if.slave  bus
);

  localparam int unsigned MAG_W  = SAMPLE_W - 1;
  localparam int unsigned ACC_W  = MAG_W + AVG_LOG2;
  localparam int unsigned PRE_W  = $clog2(PWM_DIV);
  // Dropping AVG_LOG2 bits averages; dropping MAG_W-PWM_RES more keeps the MSBs.
  localparam int unsigned RAW_SH = AVG_LOG2 + MAG_W - PWM_RES;

  localparam logic [AVG_LOG2-1:0] WIN_LAST   = '1;
  localparam logic [PWM_RES-1:0]  FRAME_LAST = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PWM_DIV - 1);
  localparam logic [1:0]          MODE_PEAK  = 2'd1;
  localparam logic [1:0]          MODE_TEST  = 2'd2;

  logic [SAMPLE_W-1:0]                 smp;
  logic [NUM_CH-1:0][MAG_W-1:0]        mag_c;
  logic [NUM_CH-1:0][MAG_W-1:0]        mag_q;
  logic [NUM_CH-1:0]                   mag_vld;
  logic [NUM_CH-1:0][ACC_W-1:0]        acc_q;
  logic [NUM_CH-1:0][AVG_LOG2-1:0]     win_cnt;
  logic [NUM_CH-1:0][ACC_W-1:0]        sum_c;
  logic [NUM_CH-1:0][PWM_RES-1:0]      raw_c;
  logic [NUM_CH-1:0][PWM_RES-1:0]      lvl_nxt_c;
  logic [NUM_CH-1:0][PWM_RES-1:0]      level_q;
  logic [PRE_W-1:0]                    prescaler;
  logic                                tick_c;
  logic [PWM_RES-1:0]                  frame_cnt;
  logic [NUM_CH-1:0][PWM_RES-1:0]      duty;
  logic [NUM_CH-1:0]                   vu_q;

  // Saturating rectifier: the most negative code maps to the largest magnitude.
  always_comb begin
    smp   = '0;
    mag_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      smp = bus.audio_signal[i*SAMPLE_W +: SAMPLE_W];
      if (!smp[SAMPLE_W-1])
        mag_c[i] = smp[MAG_W-1:0];
      else if (smp[MAG_W-1:0] == '0)
        mag_c[i] = '1;
      else
        mag_c[i] = MAG_W'(~smp + SAMPLE_W'(1));
    end
  end

  // Magnitude stage; a strobe while audio is disabled never becomes valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_q   <= '0;
      mag_vld <= '0;
    end else begin
      mag_vld <= bus.data_en & {NUM_CH{bus.audio_enable}};
      for (int i = 0; i < NUM_CH; i++)
        if (bus.data_en[i] && bus.audio_enable) mag_q[i] <= mag_c[i];
    end
  end

  // Window sum, scaled level and ballistics target per channel.
  always_comb begin
    sum_c     = '0;
    raw_c     = '0;
    lvl_nxt_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_c[i]     = acc_q[i] + ACC_W'(mag_q[i]);
      raw_c[i]     = PWM_RES'(sum_c[i] >> RAW_SH);
      lvl_nxt_c[i] = raw_c[i];
      // Peak-hold releases by one step per window and stops at zero.
      if (bus.mode == MODE_PEAK && raw_c[i] <= level_q[i])
        lvl_nxt_c[i] = (level_q[i] != '0) ? level_q[i] - PWM_RES'(1) : '0;
    end
  end

  // Accumulate and update level at each window end; disable flushes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      win_cnt <= '0;
      level_q <= '0;
    end else if (!bus.audio_enable) begin
      acc_q   <= '0;
      win_cnt <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mag_vld[i]) begin
          win_cnt[i] <= win_cnt[i] + AVG_LOG2'(1);
          if (win_cnt[i] == WIN_LAST) begin
            acc_q[i]   <= '0;
            level_q[i] <= lvl_nxt_c[i];
          end else begin
            acc_q[i] <= sum_c[i];
          end
        end
      end
    end
  end

  assign tick_c = (prescaler == PRE_LAST);

  // Shared PWM timebase; duty only reloads on the last tick of a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      frame_cnt <= '0;
      duty      <= '0;
      vu_q      <= '0;
    end else begin
      prescaler <= tick_c ? '0 : prescaler + PRE_W'(1);
      if (tick_c) frame_cnt <= frame_cnt + PWM_RES'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (tick_c && frame_cnt == FRAME_LAST)
          duty[i] <= (bus.mode == MODE_TEST) ? bus.test_level : level_q[i];
        vu_q[i] <= (frame_cnt < duty[i]);
      end
    end
  end

  assign bus.level  = level_q;
  assign bus.vu_out = vu_q;

endmodule

// File: tb/tb_vu_meter_pwm_array.sv
// Self-checking bench for vu_meter_pwm_array: table-driven window vectors,
// PWM duty measurement, audio_enable/reset corner sequences and a random
// phase checked against a behavioural window/ballistics model.
module tb_vu_meter_pwm_array;

  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned AVG_LOG2 = 4;
  localparam int unsigned PWM_RES  = 7;
  localparam int unsigned PWM_DIV  = 4;
  localparam int FRAME   = PWM_DIV * (1 << PWM_RES);
  localparam int WIN     = 1 << AVG_LOG2;
  localparam int MAG_MAX = (1 << (SAMPLE_W - 1)) - 1;
  localparam int LW      = NUM_CH * PWM_RES;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a0, b0, a1, b1;  // even/odd strobe samples per channel
    int         exp0, exp1;
    bit         pwm;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_sum[NUM_CH];
  int m_cnt[NUM_CH];
  int m_lvl[NUM_CH];
  int m_hi[NUM_CH];
  int m_ri[NUM_CH];

  vu_meter_pwm_array_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PWM_RES(PWM_RES)) bus ();

  vu_meter_pwm_array #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .AVG_LOG2(AVG_LOG2),
    .PWM_RES(PWM_RES), .PWM_DIV(PWM_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lvl(input int ch);
    return int'(bus.level[ch*PWM_RES +: PWM_RES]);
  endfunction

  // One clock cycle of strobes; returns at the following falling edge.
  task automatic drive_cycle(input logic [1:0] en, input logic [7:0] s0, input logic [7:0] s1);
    bus.data_en      = en;
    bus.audio_signal = {s1, s0};
    @(negedge clk);
    bus.data_en = '0;
  endtask

  // Count high cycles and rising edges over one frame length.
  task automatic measure_pwm();
    logic [NUM_CH-1:0] prev;
    prev = bus.vu_out;
    for (int c = 0; c < NUM_CH; c++) begin
      m_hi[c] = 0;
      m_ri[c] = 0;
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.vu_out[c]) m_hi[c]++;
        if (bus.vu_out[c] && !prev[c]) m_ri[c]++;
      end
      prev = bus.vu_out;
    end
  endtask

  function automatic int rect(input logic [SAMPLE_W-1:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > MAG_MAX) v = MAG_MAX;
    return v;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sum[c] = 0;
      m_cnt[c] = 0;
      m_lvl[c] = 0;
    end
  endfunction

  function automatic void model_strobe(input int ch, input logic [SAMPLE_W-1:0] s, input int mode);
    int raw;
    m_sum[ch] += rect(s);
    m_cnt[ch]++;
    if (m_cnt[ch] == WIN) begin
      raw = (m_sum[ch] / WIN) >> (SAMPLE_W - 1 - PWM_RES);
      if (mode == 1) begin
        if (raw > m_lvl[ch]) m_lvl[ch] = raw;
        else if (m_lvl[ch] > 0) m_lvl[ch] = m_lvl[ch] - 1;
      end else begin
        m_lvl[ch] = raw;
      end
      m_sum[ch] = 0;
      m_cnt[ch] = 0;
    end
  endfunction

  function automatic logic [LW-1:0] model_pack();
    logic [LW-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*PWM_RES +: PWM_RES] = PWM_RES'(m_lvl[c]);
    return r;
  endfunction

  vec_t vecs[9];
  logic [LW-1:0] hist[$];
  logic [LW-1:0] exp_l;
  logic [1:0]    rmode;
  logic [1:0]    ren;
  logic          rena;
  logic [15:0]   rsmp;
  int            cnt;

  initial begin
    vecs[0] = '{2'd0, 8'h40, 8'h40, 8'h00, 8'h00,  64,   0, 1'b1};
    vecs[1] = '{2'd0, 8'hC0, 8'hC0, 8'h80, 8'h80,  64, 127, 1'b1};
    vecs[2] = '{2'd0, 8'h20, 8'hE0, 8'h7F, 8'h81,  32, 127, 1'b0};
    vecs[3] = '{2'd1, 8'h64, 8'h64, 8'h00, 8'h00, 100, 126, 1'b0};
    vecs[4] = '{2'd1, 8'h00, 8'h00, 8'h00, 8'h00,  99, 125, 1'b0};
    vecs[5] = '{2'd1, 8'h00, 8'h00, 8'h10, 8'h10,  98, 124, 1'b0};
    vecs[6] = '{2'd0, 8'h3C, 8'h3C, 8'h00, 8'h00,  60,   0, 1'b0};
    vecs[7] = '{2'd1, 8'h32, 8'h32, 8'h00, 8'h00,  59,   0, 1'b0};
    vecs[8] = '{2'd3, 8'h01, 8'h03, 8'h0F, 8'h00,   2,   7, 1'b0};

    reset             = 1'b1;
    bus.data_en       = '0;
    bus.audio_enable  = 1'b1;
    bus.audio_signal  = '0;
    bus.mode          = 2'd0;
    bus.test_level    = '0;
    repeat (2) @(negedge clk);
    check("reset_level", int'(bus.level), 0);
    check("reset_vu", int'(bus.vu_out), 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven windows: 16 back-to-back strobes on both channels.
    foreach (vecs[v]) begin
      bus.mode = vecs[v].mode;
      for (int k = 0; k < WIN; k++)
        drive_cycle(2'b11, k[0] ? vecs[v].b0 : vecs[v].a0, k[0] ? vecs[v].b1 : vecs[v].a1);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_level0", v), lvl(0), vecs[v].exp0);
      check($sformatf("vec%0d_level1", v), lvl(1), vecs[v].exp1);
      if (vecs[v].pwm) begin
        repeat (FRAME + 100) @(negedge clk);
        measure_pwm();
        check($sformatf("vec%0d_high0", v), m_hi[0], vecs[v].exp0 * PWM_DIV);
        check($sformatf("vec%0d_high1", v), m_hi[1], vecs[v].exp1 * PWM_DIV);
        check($sformatf("vec%0d_rise0", v), m_ri[0], (vecs[v].exp0 > 0) ? 1 : 0);
        check($sformatf("vec%0d_rise1", v), m_ri[1], (vecs[v].exp1 > 0) ? 1 : 0);
      end
    end

    // Test mode overrides the measured levels for both channels.
    bus.mode       = 2'd2;
    bus.test_level = 7'd32;
    repeat (FRAME + 100) @(negedge clk);
    measure_pwm();
    check("test_high0", m_hi[0], 32 * PWM_DIV);
    check("test_high1", m_hi[1], 32 * PWM_DIV);
    check("test_rise0", m_ri[0], 1);
    check("test_rise1", m_ri[1], 1);

    // audio_enable drop discards a partial window and the same-cycle strobe.
    bus.mode = 2'd0;
    repeat (10) drive_cycle(2'b11, 8'h40, 8'h40);
    bus.audio_enable = 1'b0;
    drive_cycle(2'b11, 8'h40, 8'h40);
    check("endrop_level0", lvl(0), 0);
    check("endrop_level1", lvl(1), 0);
    bus.audio_enable = 1'b1;
    repeat (WIN - 1) drive_cycle(2'b11, 8'h10, 8'h10);
    repeat (2) @(negedge clk);
    check("reen_partial0", lvl(0), 0);
    check("reen_partial1", lvl(1), 0);
    drive_cycle(2'b11, 8'h10, 8'h10);
    repeat (2) @(negedge clk);
    check("reen_full0", lvl(0), 16);
    check("reen_full1", lvl(1), 16);

    // Random phase against the window/ballistics model; level lags strobes by 2.
    model_clear();
    m_lvl[0] = 16;
    m_lvl[1] = 16;
    hist.push_back(model_pack());
    hist.push_back(model_pack());
    rmode = 2'd0;
    for (int cyc = 0; cyc < 768; cyc++) begin
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       rmode = 2'd0;
          1:       rmode = 2'd1;
          default: rmode = 2'd3;
        endcase
      end
      bus.mode = rmode;
      exp_l = hist.pop_front();
      check("rand_level", int'(bus.level), int'(exp_l));
      // Quiet cycles before each mode change keep in-flight windows on the old mode.
      ren  = (cyc % 64 >= 62) ? 2'b00 : 2'($urandom);
      rena = (cyc % 64 >= 62) ? 1'b1 : ($urandom_range(0, 47) != 0);
      rsmp = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rsmp[7:0] = 8'h80;
      bus.data_en      = ren;
      bus.audio_enable = rena;
      bus.audio_signal = rsmp;
      if (!rena) begin
        model_clear();
        hist[0] = '0;
      end else begin
        for (int c = 0; c < NUM_CH; c++)
          if (ren[c]) model_strobe(c, rsmp[c*SAMPLE_W +: SAMPLE_W], int'(rmode));
      end
      hist.push_back(model_pack());
      @(negedge clk);
    end
    bus.data_en      = '0;
    bus.audio_enable = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset while the PWM output is high.
    bus.mode       = 2'd2;
    bus.test_level = 7'd64;
    cnt = 0;
    while (cnt < 2 * FRAME + 200 && !bus.vu_out[0]) begin
      @(negedge clk);
      cnt++;
    end
    check("pre_reset_vu_high", int'(bus.vu_out[0]), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_vu", int'(bus.vu_out), 0);
    check("async_reset_level", int'(bus.level), 0);
    bus.mode = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    measure_pwm();
    check("post_reset_high0", m_hi[0], 0);
    check("post_reset_high1", m_hi[1], 0);

    // Frame restarts at zero: first test-mode pulse lands on a fixed cycle.
    @(negedge clk);
    reset          = 1'b1;
    bus.mode       = 2'd2;
    bus.test_level = 7'd32;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (cnt < 2 * FRAME + 200 && !bus.vu_out[0]) begin
      @(negedge clk);
      cnt++;
    end
    check("first_rise_cycle", cnt, FRAME + 1);
    check("first_rise_ch1", int'(bus.vu_out[1]), 1);
    measure_pwm();
    check("restart_high0", m_hi[0], 32 * PWM_DIV);
    check("restart_high1", m_hi[1], 32 * PWM_DIV);
    check("restart_rise0", m_ri[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
